// File: rtl/timer_cmp.sv
// timer_cmp: compare/interrupt stage behind the free-running cycle counter.
// Raises a level interrupt when cnt reaches CMP (wrap-safe, modulo 2^32).
// The interrupt can be one-shot or periodic (auto-reload of CMP by PERIOD).
// Optional feature macro: TIMER_CMP_OVERRUN_EN adds the sticky STATUS.overrun bit.
module timer_cmp (
    input  logic        rst,
    input  logic        clk,
    input  logic [31:0] cnt,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] A_CMP    = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_PERIOD = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        per_q, per_d;
    logic [31:0] period_q, period_d;
    logic        pend_q, pend_d;
    logic        ovr;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_cmp, wr_ctrl, wr_period, wr_status;
    logic [31:0] diff;
    logic        hit, reload;
    logic [31:0] rd_mux;

    assign wr_cmp    = we && (addr == A_CMP);
    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_period = we && (addr == A_PERIOD);
    assign wr_status = we && (addr == A_STATUS);

    // Signed-distance test: cnt is at or past CMP when (cnt - CMP) is
    // non-negative as a 32-bit two's complement value, which survives wrap.
    assign diff   = cnt - cmp_q;
    assign hit    = (state_q == ST_ARMED) && !diff[31];
    assign reload = hit && per_q && (period_q != 32'd0);

    // FSM next state; disabling via CTRL overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (wr_ctrl && wdata[0]) state_d = ST_ARMED;
            // A CMP write in the hit cycle supplies a fresh target, so stay armed
            ST_ARMED: if (hit && !reload && !wr_cmp) state_d = ST_FIRED;
            ST_FIRED: if (wr_cmp) state_d = ST_ARMED;
            default:  state_d = ST_IDLE;
        endcase
        if (wr_ctrl && !wdata[0]) state_d = ST_IDLE;
    end

    // Register file next-state: software CMP write beats the periodic reload,
    // and a hit beats a simultaneous write-1-to-clear of pending
    always_comb begin
        cmp_d    = cmp_q;
        en_d     = en_q;
        per_d    = per_q;
        period_d = period_q;
        if (wr_cmp)        cmp_d = wdata;
        else if (reload)   cmp_d = cmp_q + period_q;
        if (wr_ctrl) begin
            en_d  = wdata[0];
            per_d = wdata[1];
        end
        if (wr_period)     period_d = wdata;
        pend_d = (pend_q && !(wr_status && wdata[0])) || hit;
    end

`ifdef TIMER_CMP_OVERRUN_EN
    logic ovr_q, ovr_d;

    // Sticky overrun: any hit that lands while pending is still set
    always_comb begin
        ovr_d = (ovr_q && !(wr_status && wdata[1])) || (hit && pend_q);
    end

    // Overrun flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovr_q <= 1'b0;
        else      ovr_q <= ovr_d;
    end

    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

    // Read mux samples the pre-edge register values, so a same-cycle write
    // to the addressed register returns the old contents
    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            A_CMP:    rd_mux = cmp_q;
            A_CTRL:   rd_mux = {30'd0, per_q, en_q};
            A_PERIOD: rd_mux = period_q;
            A_STATUS: rd_mux = {30'd0, ovr, pend_q};
            default:  rd_mux = 32'd0;
        endcase
        rdata_d = re ? rd_mux : rdata_q;
    end

    // State and register update with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cmp_q    <= 32'hFFFF_FFFF;
            en_q     <= 1'b0;
            per_q    <= 1'b0;
            period_q <= 32'd0;
            pend_q   <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cmp_q    <= cmp_d;
            en_q     <= en_d;
            per_q    <= per_d;
            period_q <= period_d;
            pend_q   <= pend_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = pend_q;

endmodule

// File: tb/tb_timer_cmp.sv
// tb_timer_cmp: directed, table-driven bench for timer_cmp.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_timer_cmp;

    localparam logic [1:0] A_CMP = 2'd0, A_CTRL = 2'd1, A_PERIOD = 2'd2, A_STATUS = 2'd3;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_FIRED = 2'd2;
    localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_RW = 2'd2;

    logic        rst, clk, we, re;
    logic [1:0]  addr;
    logic [31:0] cnt, wdata, rdata;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;
    bit run    = 0;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    timer_cmp dut (
        .rst(rst), .clk(clk), .cnt(cnt), .we(we), .re(re),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // one clock: cnt advances across the edge when the counter is running
    task automatic cyc();
        @(posedge clk);
        #1;
        if (run) cnt = cnt + 32'd1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a; re = 1'b1;
        cyc();
        re = 1'b0;
        v = rdata;
    endtask

    task automatic rdwr(input logic [1:0] a, input logic [31:0] d, output logic [31:0] v);
        addr = a; wdata = d; we = 1'b1; re = 1'b1;
        cyc();
        we = 1'b0; re = 1'b0;
        v = rdata;
    endtask

    task automatic do_reset();
        run = 0; we = 1'b0; re = 1'b0;
        rst = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
    endtask

    logic [31:0] v;
    logic [31:0] hits[$];
    logic [31:0] exp_hits[4];
    logic [31:0] exp_status;

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = 2'd0; wdata = 32'd0; cnt = 32'd0;
        exp_hits[0] = 32'd10; exp_hits[1] = 32'd15; exp_hits[2] = 32'd20; exp_hits[3] = 32'd25;

        tbl[0]  = '{OP_RD, A_CMP,    32'd0,          32'hFFFF_FFFF};
        tbl[1]  = '{OP_RD, A_CTRL,   32'd0,          32'd0};
        tbl[2]  = '{OP_RD, A_PERIOD, 32'd0,          32'd0};
        tbl[3]  = '{OP_RD, A_STATUS, 32'd0,          32'd0};
        tbl[4]  = '{OP_WR, A_PERIOD, 32'h1234_5678,  32'd0};
        tbl[5]  = '{OP_RD, A_PERIOD, 32'd0,          32'h1234_5678};
        tbl[6]  = '{OP_RW, A_PERIOD, 32'hA5A5_A5A5,  32'h1234_5678};
        tbl[7]  = '{OP_RD, A_PERIOD, 32'd0,          32'hA5A5_A5A5};
        tbl[8]  = '{OP_WR, A_CTRL,   32'hFFFF_FFFE,  32'd0};
        tbl[9]  = '{OP_RD, A_CTRL,   32'd0,          32'd2};
        tbl[10] = '{OP_WR, A_CMP,    32'hDEAD_BEEF,  32'd0};
        tbl[11] = '{OP_RD, A_CMP,    32'd0,          32'hDEAD_BEEF};
        tbl[12] = '{OP_WR, A_STATUS, 32'hFFFF_FFFF,  32'd0};
        tbl[13] = '{OP_RD, A_STATUS, 32'd0,          32'd0};

        #2 rst = 1'b0;
        do_reset();
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});

        // register-port table: reset values, write/read, same-cycle rd/wr, masking
        for (int i = 0; i < 14; i++) begin
            case (tbl[i].op)
                OP_WR: wr(tbl[i].addr, tbl[i].data);
                OP_RD: begin
                    rd(tbl[i].addr, v);
                    chk($sformatf("tbl%0d_rd", i), v, tbl[i].exp);
                end
                default: begin
                    rdwr(tbl[i].addr, tbl[i].data, v);
                    chk($sformatf("tbl%0d_rdwr", i), v, tbl[i].exp);
                end
            endcase
            chk($sformatf("tbl%0d_irq", i), {31'd0, irq}, 32'd0);
        end
        chk("tbl_state_idle", {30'd0, dut.state_q}, {30'd0, S_IDLE});

        // one-shot
        do_reset();
        cnt = 32'd90;
        wr(A_CMP, 32'd100);
        wr(A_CTRL, 32'd1);
        run = 1;
        while (cnt < 32'd100) begin
            cyc();
            chk("oneshot_pre_irq", {31'd0, irq}, 32'd0);
        end
        cyc();
        chk("oneshot_rise", {31'd0, irq}, 32'd1);
        chk("oneshot_state", {30'd0, dut.state_q}, {30'd0, S_FIRED});
        wr(A_STATUS, 32'd1);
        chk("oneshot_clear", {31'd0, irq}, 32'd0);
        while (cnt < 32'd205) begin
            cyc();
            chk("oneshot_norefire", {31'd0, irq}, 32'd0);
        end
        // re-arm with a target already in the past: hit on the next cycle
        wr(A_CMP, 32'd50);
        chk("rearm_wcycle", {31'd0, irq}, 32'd0);
        cyc();
        chk("rearm_hit", {31'd0, irq}, 32'd1);

        // wrap-safe
        do_reset();
        cnt = 32'hFFFF_FFF0;
        wr(A_CMP, 32'h0000_0008);
        wr(A_CTRL, 32'd1);
        run = 1;
        while (cnt != 32'd8) begin
            cyc();
            chk("wrap_pre_irq", {31'd0, irq}, 32'd0);
        end
        cyc();
        chk("wrap_rise", {31'd0, irq}, 32'd1);

        // periodic with clear after every hit
        do_reset();
        cnt = 32'd0;
        wr(A_CMP, 32'd10);
        wr(A_PERIOD, 32'd5);
        wr(A_CTRL, 32'd3);
        run = 1;
        hits.delete();
        while (cnt < 32'd28) begin
            cyc();
            if (irq) begin
                hits.push_back(cnt - 32'd1);
                wr(A_STATUS, 32'd1);
            end
        end
        run = 0;
        chk("per_nhits", 32'(hits.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < hits.size()) chk($sformatf("per_hit%0d", i), hits[i], exp_hits[i]);
        rd(A_CMP, v);
        chk("per_cmp_final", v, 32'd30);
        chk("per_state", {30'd0, dut.state_q}, {30'd0, S_ARMED});

        // simultaneous clear + hit, then overrun, then CMP write vs reload
        do_reset();
        cnt = 32'd0;
        wr(A_CMP, 32'd10);
        wr(A_PERIOD, 32'd5);
        wr(A_CTRL, 32'd3);
        cnt = 32'd10;
        wr(A_STATUS, 32'd1);
        chk("simul_pending", {31'd0, irq}, 32'd1);
        cnt = 32'd15;
        cyc();
        rd(A_STATUS, v);
`ifdef TIMER_CMP_OVERRUN_EN
        exp_status = 32'd3;
`else
        exp_status = 32'd1;
`endif
        chk("overrun_status", v, exp_status);
        wr(A_STATUS, 32'd2);
        rd(A_STATUS, v);
        chk("overrun_w1c", v, 32'd1);
        cnt = 32'd20;
        wr(A_CMP, 32'd100);
        rd(A_CMP, v);
        chk("cmpwr_beats_reload", v, 32'd100);

        // asynchronous reset while the interrupt is asserted
        do_reset();
        cnt = 32'd0;
        wr(A_CMP, 32'd10);
        wr(A_PERIOD, 32'd5);
        wr(A_CTRL, 32'd3);
        cnt = 32'd10;
        cyc();
        chk("midrst_pre_irq", {31'd0, irq}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_irq_async", {31'd0, irq}, 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
        rd(A_CTRL, v);
        chk("midrst_ctrl", v, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_cmp.md
# timer_cmp

Compare/interrupt stage that consumes the free-running 32-bit cycle count from the cycle counter and raises a timer interrupt when the count reaches a programmable compare value. It sits directly downstream of the counter and upstream of the interrupt controller. Software reaches it through a small register port. It supports one-shot and periodic (auto-reload) modes with a wrap-safe comparison.

## Interface
- Parameters: none; all widths are fixed at 32 bits.
- `rst`  in  1  asynchronous, active-low reset.
- `clk`  in  1  clock.
- `cnt`  in  32  current count from the cycle counter; advances by 1 per `clk`.
- `we`  in  1  register write strobe.
- `re`  in  1  register read strobe.
- `addr`  in  2  register select: 0 CMP, 1 CTRL, 2 PERIOD, 3 STATUS.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, registered.
- `irq`  out  1  timer interrupt, level, registered; equals STATUS.pending.

## Operation
- Registers:
  - CMP: 32-bit compare value.
  - CTRL: bit0 `en`, bit1 `periodic`.
  - PERIOD: 32-bit reload increment.
  - STATUS: bit0 `pending`, bit1 `overrun`. Bits are write-1-to-clear. Other bits read 0.
- Match condition: `hit = (cnt - CMP)[31] == 0`, evaluated modulo 2^32. The comparison is therefore correct across counter wrap, provided CMP is within 2^31 ahead of `cnt`.
- FSM states: IDLE, ARMED, FIRED.
  - IDLE: `en` = 0; no hits are detected. A write of CTRL with `en` = 1 moves to ARMED.
  - ARMED, when `hit`:
    - Set `pending`.
    - If `periodic` = 1 and PERIOD ≠ 0: `CMP <= CMP + PERIOD` (32-bit wrap) and remain in ARMED.
    - Otherwise: go to FIRED.
  - FIRED: no further hits. A write to CMP re-arms (go to ARMED). A write of CTRL with `en` = 0 goes to IDLE.
  - Any state: a write of CTRL with `en` = 0 goes to IDLE. `pending` and `overrun` are retained.
- Hit while `pending` is already 1 (periodic mode): `pending` stays 1 and `overrun` is set (see Configuration).
- Simultaneous write-1-to-clear of `pending` and a new hit in the same cycle: the hit wins and `pending` = 1 afterwards.
- A CMP write and a periodic reload in the same cycle: the software write wins and no reload is applied.
- A CMP write takes effect for comparison on the next cycle. If the new value is already reached, the hit occurs on that next cycle.
- Reads: when `re` = 1, `rdata` is loaded with the addressed register on the next edge. Otherwise `rdata` holds its value.
- Read/write of the same address in one cycle: `rdata` returns the old value.

## Timing
- Reset (`rst` = 0, asynchronous) forces:
  - FSM to IDLE.
  - CMP = 0xFFFFFFFF, CTRL = 0, PERIOD = 0, STATUS = 0.
  - `rdata` = 0, `irq` = 0.
- Reset mid-operation aborts any pending interrupt immediately, without waiting for a clock edge.
- Hit latency: `cnt` reaching CMP in cycle N gives `irq` = 1 after edge N+1 (one registered stage).
- `irq` falls on the edge following a STATUS write of bit0 = 1, unless a simultaneous hit occurs.
- Read latency: 1 cycle from `re` to valid `rdata`.
- Register writes commit on the `clk` edge where `we` = 1.

## Configuration
- `TIMER_CMP_OVERRUN_EN` defined: STATUS bit1 `overrun` is implemented.
  - It is a sticky bit, set by any hit that occurs while `pending` = 1.
  - It is cleared by writing 1 to bit1, or by reset.
- Not defined: the overrun logic is removed. STATUS bit1 reads 0, writes to it are ignored, and a hit while pending has no visible effect beyond keeping `pending` = 1.

## Test plan
- Reset state: hold `rst` = 0, then release, then read all 4 registers. Required: CMP = 0xFFFFFFFF, CTRL = 0, PERIOD = 0, STATUS = 0, `irq` = 0.
- One-shot: CMP = 100, CTRL = 1, `cnt` ramping from 90. Required:
  - `irq` rises one cycle after `cnt` = 100.
  - FSM in FIRED.
  - Writing STATUS = 1 drops `irq` the next cycle.
  - No re-fire at `cnt` = 200.
- Wrap-safe: `cnt` starting at 0xFFFFFFF0, CMP = 0x00000008, `en` = 1. Required: no `irq` before the wrap; `irq` one cycle after `cnt` = 8.
- Periodic: CMP = 10, PERIOD = 5, CTRL = 3, clearing pending after each hit. Required: hits at `cnt` = 10, 15, 20, 25; CMP reads 30 afterwards.
- Simultaneous events:
  - Periodic mode with STATUS clear written in the exact hit cycle: `pending` remains 1.
  - With `TIMER_CMP_OVERRUN_EN`, leaving pending uncleared across two hits sets STATUS = 0x3.
  - Without the macro, the same stimulus gives STATUS = 0x1.
- Reset mid-operation: assert `rst` = 0 asynchronously while `irq` = 1 in periodic mode. Required: `irq` = 0 immediately, and the FSM is in IDLE after release.
